// File: rtl/fifo_rd_packer_pkg.sv
// Shared defaults, flush FSM encoding and counter-width helpers for the FIFO read-side packer.
package fifo_rd_packer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_RATIO = 4;

  typedef enum logic [1:0] {
    FL_IDLE  = 2'd0,
    FL_DRAIN = 2'd1,
    FL_EMIT  = 2'd2
  } flush_state_e;

  // Counter must hold RATIO itself; a lane index only needs 0..RATIO-1.
  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  function automatic int lane_width(input int ratio);
    return $clog2(ratio);
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port, flush request and packed output stream of fifo_rd_packer, named from the packer's side.
interface fifo_rd_packer_if
  import fifo_rd_packer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RATIO = DEF_RATIO
);
  logic                     empty_i;
  logic                     rd_en_o;
  logic [WIDTH-1:0]         rdata_i;
  logic                     flush_i;
  logic                     m_valid_o;
  logic                     m_ready_i;
  logic [WIDTH*RATIO-1:0]   m_data_o;
  logic [RATIO-1:0]         m_keep_o;
  logic                     m_last_o;
  logic                     busy_o;

  modport slave (
    input  empty_i, rdata_i, flush_i, m_ready_i,
    output rd_en_o, m_valid_o, m_data_o, m_keep_o, m_last_o, busy_o
  );

  modport master (
    output empty_i, rdata_i, flush_i, m_ready_i,
    input  rd_en_o, m_valid_o, m_data_o, m_keep_o, m_last_o, busy_o
  );
endinterface

// File: rtl/fifo_rd_packer_pack_out_reg.sv
// One-entry valid/ready holding register for a packed beat; accepts a new beat on the same edge
// the held one is taken, so back-to-back beats flow without a bubble.
module fifo_rd_packer_pack_out_reg #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  input  logic [KW-1:0] in_keep_i,
  input  logic          in_last_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [KW-1:0] out_keep_o,
  output logic          out_last_o
);
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q,  data_d;
  logic [KW-1:0] keep_q,  keep_d;
  logic          last_q,  last_d;

  assign in_ready_o = !valid_q || out_ready_i;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
      keep_d  = in_keep_i;
      last_d  = in_last_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_keep_o  = keep_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains async_fifo words and packs RATIO of them (lane 0 = first read) into one wide beat;
// a flush emits the partially filled beat with a keep mask and last.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RATIO = DEF_RATIO,
  parameter int CW    = cnt_width(RATIO)
) (
  input logic             clk_i,
  input logic             rst_n_i,
  fifo_rd_packer_if.slave bus
);
  localparam int            LW      = lane_width(RATIO);
  localparam logic [CW-1:0] RATIO_C = CW'(RATIO);

  flush_state_e                state_q, state_d;
  logic [CW-1:0]               slot_cnt_q, slot_cnt_d;
  logic [CW-1:0]               land_cnt_q, land_cnt_d;
  logic                        inflight_q, inflight_d;
  logic [LW-1:0]               lane_q, lane_d;
  logic [RATIO-1:0][WIDTH-1:0] acc_q, acc_d;

  logic             rd_en;
  logic             beat_valid, beat_ready, beat_xfer, beat_last;
  logic [RATIO-1:0] beat_keep;

  // Gated by reset so the FIFO is never popped while the packer is held in reset.
  assign rd_en = rst_n_i && !bus.empty_i && (slot_cnt_q < RATIO_C) && (state_q == FL_IDLE);

  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    land_cnt_d = land_cnt_q;
    inflight_d = 1'b0;
    lane_d     = lane_q;
    acc_d      = acc_q;
    beat_valid = 1'b0;
    beat_keep  = '1;
    beat_last  = 1'b0;

    if (state_q == FL_EMIT) begin
      if (land_cnt_q != '0) begin
        beat_valid = 1'b1;
        beat_last  = 1'b1;
        for (int k = 0; k < RATIO; k++) beat_keep[k] = (CW'(k) < land_cnt_q);
      end
    end else if (land_cnt_q == RATIO_C) begin
      beat_valid = 1'b1;
    end
    beat_xfer = beat_valid && beat_ready;

    if (rd_en) begin
      slot_cnt_d = slot_cnt_q + CW'(1);
      inflight_d = 1'b1;
      lane_d     = slot_cnt_q[LW-1:0];
    end
    if (inflight_q) begin
      acc_d[lane_q] = bus.rdata_i;
      land_cnt_d    = land_cnt_q + CW'(1);
    end
    // Clearing the accumulator on transfer is what zeroes unused lanes of a later partial beat.
    if (beat_xfer) begin
      slot_cnt_d = '0;
      land_cnt_d = '0;
      acc_d      = '0;
    end

    unique case (state_q)
      FL_IDLE:  if (bus.flush_i) state_d = FL_DRAIN;
      FL_DRAIN: if (!inflight_q) state_d = FL_EMIT;
      FL_EMIT:  if (land_cnt_q == '0 || beat_xfer) state_d = FL_IDLE;
      default:  state_d = FL_IDLE;
    endcase
  end

  // NOTE: the accumulator is reset too: partial beats rely on never-written lanes reading as zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= FL_IDLE;
      slot_cnt_q <= '0;
      land_cnt_q <= '0;
      inflight_q <= 1'b0;
      lane_q     <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      land_cnt_q <= land_cnt_d;
      inflight_q <= inflight_d;
      lane_q     <= lane_d;
      acc_q      <= acc_d;
    end
  end

  fifo_rd_packer_pack_out_reg #(
    .DW (WIDTH*RATIO),
    .KW (RATIO)
  ) u_out_reg (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_valid_i  (beat_valid),
    .in_ready_o  (beat_ready),
    .in_data_i   (acc_q),
    .in_keep_i   (beat_keep),
    .in_last_i   (beat_last),
    .out_valid_o (bus.m_valid_o),
    .out_ready_i (bus.m_ready_i),
    .out_data_o  (bus.m_data_o),
    .out_keep_o  (bus.m_keep_o),
    .out_last_o  (bus.m_last_o)
  );

  assign bus.rd_en_o = rd_en;
  assign bus.busy_o  = (slot_cnt_q != '0) || (state_q != FL_IDLE) || bus.m_valid_o;

endmodule
